// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: two-digit multiplexed 7-segment driver for a 0..31 binary value.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in[4:0]   value offer; accepted when in_ready is high
//   in_ready            one-entry pending register is empty
//   dig_en[1:0]         one-hot digit enable ([0] units, [1] tens)
//   seg[6:0]            segments {g,f,e,d,c,b,a}, active-high
//   digit_bcd[3:0]      BCD digit currently driven
//   frame_start         pulse on the first cycle of each units slot after a frame wrap
module bcd_display_scanner #(
    parameter int SCAN_DIV      = 50000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [4:0] in,
    output logic       in_ready,
    output logic [1:0] dig_en,
    output logic [6:0] seg,
    output logic [3:0] digit_bcd,
    output logic       frame_start
);
    localparam int CW = $clog2(SCAN_DIV);

    typedef enum logic {SCAN_D0, SCAN_D1} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] scan_cnt, cnt_nx;
    logic [4:0]    disp_val, disp_nx, pend_val;
    logic          pend_full, wrap, commit, accept, blank;
    logic [3:0]    bcd_nx;
    logic [1:0]    en_nx;
    logic [6:0]    seg_nx;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'h3F;
            4'd1: seg7 = 7'h06;
            4'd2: seg7 = 7'h5B;
            4'd3: seg7 = 7'h4F;
            4'd4: seg7 = 7'h66;
            4'd5: seg7 = 7'h6D;
            4'd6: seg7 = 7'h7D;
            4'd7: seg7 = 7'h07;
            4'd8: seg7 = 7'h7F;
            4'd9: seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    assign in_ready = ~pend_full;
    assign accept   = in_valid & ~pend_full;

    // Outputs are computed from the next state/value so they register on the
    // same edge as the state and counter they describe.
    always_comb begin
        wrap     = scan_cnt == CW'(SCAN_DIV - 1);
        commit   = wrap && state == SCAN_D1;
        cnt_nx   = wrap ? '0 : scan_cnt + CW'(1);
        state_nx = wrap ? (state == SCAN_D0 ? SCAN_D1 : SCAN_D0) : state;
        disp_nx  = (commit && pend_full) ? pend_val : disp_val;
        bcd_nx   = state_nx == SCAN_D0 ? 4'(disp_nx % 5'd10) : 4'(disp_nx / 5'd10);
        blank    = BLANK_LEADING && state_nx == SCAN_D1 && disp_nx < 5'd10;
        en_nx    = blank ? 2'b00 : (state_nx == SCAN_D0 ? 2'b01 : 2'b10);
        seg_nx   = blank ? 7'h00 : seg7(bcd_nx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SCAN_D0;
            scan_cnt    <= '0;
            disp_val    <= '0;
            pend_val    <= '0;
            pend_full   <= 1'b0;
            dig_en      <= 2'b01;
            digit_bcd   <= 4'd0;
            seg         <= 7'h3F;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nx;
            scan_cnt    <= cnt_nx;
            disp_val    <= disp_nx;
            if (accept) pend_val <= in;
            // A commit can only clear a full register, an accept only fills an empty one.
            pend_full   <= accept | (pend_full & ~commit);
            dig_en      <= en_nx;
            digit_bcd   <= bcd_nx;
            seg         <= seg_nx;
            frame_start <= commit;
        end
    end
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: directed self-checking bench for bcd_display_scanner.
module tb_bcd_display_scanner;
    logic       clk, rst_n, in_valid;
    logic [4:0] in;
    logic       rd0, rd1, rd2, fs0, fs1, fs2;
    logic [1:0] de0, de1, de2;
    logic [6:0] sg0, sg1, sg2;
    logic [3:0] db0, db1, db2;
    int checks = 0;
    int errors = 0;

    bcd_display_scanner #(.SCAN_DIV(4), .BLANK_LEADING(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in), .in_ready(rd0),
        .dig_en(de0), .seg(sg0), .digit_bcd(db0), .frame_start(fs0));
    bcd_display_scanner #(.SCAN_DIV(4), .BLANK_LEADING(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in), .in_ready(rd1),
        .dig_en(de1), .seg(sg1), .digit_bcd(db1), .frame_start(fs1));
    bcd_display_scanner #(.SCAN_DIV(2), .BLANK_LEADING(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in), .in_ready(rd2),
        .dig_en(de2), .seg(sg2), .digit_bcd(db2), .frame_start(fs2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            step();
            n++;
        end while (!fs0 && n < 40);
        chk("frame_wait", 8'(fs0), 8'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in = 5'd0;
        step(2);
        chk("rst_en", 8'(de0), 8'h01);
        chk("rst_seg", 8'(sg0), 8'h3F);
        chk("rst_bcd", 8'(db0), 8'h00);
        chk("rst_ready", 8'(rd0), 8'h01);
        chk("rst_fs", 8'(fs0), 8'h00);
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk("u2_en", 8'(de2), ((k / 2) % 2) != 0 ? 8'h02 : 8'h01);
            chk("u2_fs", 8'(fs2), 8'(k % 4 == 0 && k > 0));
            chk("u0_fs", 8'(fs0), 8'(k == 8));
            chk("u0_en", 8'(de0), ((k / 4) % 2) != 0 ? 8'h00 : 8'h01);
            step();
        end
        chk("u0_fs16", 8'(fs0), 8'h01);
        in_valid = 1'b1;
        in = 5'd27;
        step();
        chk("l27_ready", 8'(rd0), 8'h00);
        in_valid = 1'b0;
        wait_frame();
        chk("l27_u_bcd", 8'(db0), 8'd7);
        chk("l27_u_seg", 8'(sg0), 8'h07);
        chk("l27_u_en", 8'(de0), 8'h01);
        chk("l27_ready1", 8'(rd0), 8'h01);
        step(4);
        chk("l27_t_bcd", 8'(db0), 8'd2);
        chk("l27_t_seg", 8'(sg0), 8'h5B);
        chk("l27_t_en", 8'(de0), 8'h02);
        in_valid = 1'b1;
        in = 5'd5;
        step();
        chk("l5_ready", 8'(rd0), 8'h00);
        in_valid = 1'b0;
        wait_frame();
        chk("l5_u_seg", 8'(sg0), 8'h6D);
        chk("l5_u_en", 8'(de0), 8'h01);
        chk("l5_u_seg_nb", 8'(sg1), 8'h6D);
        step(4);
        chk("l5_t_en_bl", 8'(de0), 8'h00);
        chk("l5_t_seg_bl", 8'(sg0), 8'h00);
        chk("l5_t_bcd_bl", 8'(db0), 8'h00);
        chk("l5_t_en_nb", 8'(de1), 8'h02);
        chk("l5_t_seg_nb", 8'(sg1), 8'h3F);
        in_valid = 1'b1;
        in = 5'd31;
        step();
        in = 5'd12;
        chk("b2b_hold", 8'(rd0), 8'h00);
        wait_frame();
        chk("b2b_ready", 8'(rd0), 8'h01);
        chk("b2b_31_u_bcd", 8'(db0), 8'd1);
        chk("b2b_31_u_seg", 8'(sg0), 8'h06);
        step();
        chk("b2b_12_taken", 8'(rd0), 8'h00);
        in_valid = 1'b0;
        step(3);
        chk("b2b_31_t_bcd", 8'(db0), 8'd3);
        chk("b2b_31_t_seg", 8'(sg0), 8'h4F);
        chk("b2b_31_t_en", 8'(de0), 8'h02);
        wait_frame();
        chk("b2b_12_u_bcd", 8'(db0), 8'd2);
        chk("b2b_12_u_seg", 8'(sg0), 8'h5B);
        step(4);
        chk("b2b_12_t_bcd", 8'(db0), 8'd1);
        chk("b2b_12_t_seg", 8'(sg0), 8'h06);
        in_valid = 1'b1;
        in = 5'd19;
        step();
        in_valid = 1'b0;
        chk("r19_pending", 8'(rd0), 8'h00);
        step();
        rst_n = 1'b0;
        #1;
        chk("r19_rst_en", 8'(de0), 8'h01);
        chk("r19_rst_seg", 8'(sg0), 8'h3F);
        chk("r19_rst_bcd", 8'(db0), 8'h00);
        chk("r19_rst_ready", 8'(rd0), 8'h01);
        chk("r19_rst_fs", 8'(fs0), 8'h00);
        step();
        rst_n = 1'b1;
        wait_frame();
        chk("r19_u_bcd", 8'(db0), 8'd0);
        chk("r19_u_seg", 8'(sg0), 8'h3F);
        chk("r19_u_en", 8'(de0), 8'h01);
        step(4);
        chk("r19_t_en_bl", 8'(de0), 8'h00);
        chk("r19_t_bcd_nb", 8'(db1), 8'd0);
        chk("r19_t_seg_nb", 8'(sg1), 8'h3F);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
